// File: rtl/lfsr_noise_bank_pkg.sv
// Shared constants and elaboration helpers for the LFSR noise bank.
// Tap masks are maximal-length polynomials: bit i set feeds r[i] into the feedback XOR.
package lfsr_pkg;

  localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Per-channel reset seed: base seed rotated left by 3*ch within width; zero maps to 1.
  function automatic logic [31:0] rot_seed(input logic [31:0] seed, input int width, input int ch);
    logic [31:0] mask;
    logic [31:0] s;
    logic [31:0] r;
    int amt;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    amt  = (3 * ch) % width;
    s    = seed & mask;
    r    = ((s << amt) | (s >> (width - amt))) & mask;
    if (r == '0) r = 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_noise_bank_if.sv
// Output stream of the noise bank: one packed sample set per transfer, valid/ready handshake.
interface lfsr_noise_bank_if #(
  parameter int NUM_CH    = 4,
  parameter int OUT_WIDTH = 16
);
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_CH*OUT_WIDTH-1:0] noise_out;

  modport master (output out_valid, output noise_out, input out_ready);
  modport slave  (input out_valid, input noise_out, output out_ready);
endinterface

// File: rtl/lfsr_noise_bank_core.sv
// One Fibonacci LFSR channel; state updates at the edge, load beats advance, zero seed becomes 1.
// No output stage of its own: the top decides when to advance.
module lfsr_core #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] INIT  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             zero_seed
);

  logic [WIDTH-1:0] r;

  assign zero_seed = load && (load_val == '0);
  assign state     = r;

  // An all-zero register would lock the LFSR, so a zero seed is replaced with 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= INIT;
    end else if (load) begin
      r <= zero_seed ? WIDTH'(1) : load_val;
    end else if (adv) begin
      r <= {r[WIDTH-2:0], ^(r & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_noise_bank.sv
// NUM_CH lockstep LFSR noise streams with amplitude scaling; one cycle from enable to out_valid.
// Backpressure: noise_out and all LFSR states hold while out_valid && !out_ready.
module lfsr_noise_bank
  import lfsr_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          OUT_WIDTH  = 16,
  parameter int          NUM_CH     = 4,
  parameter logic [31:0] TAPS       = TAPS_W16,
  parameter logic [31:0] SEED       = 32'h0000_ACE1,
  parameter bit          SIGNED_OUT = 1'b1,
  localparam int         CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    seed_load,
  input  logic [CH_W-1:0]         seed_ch,
  input  logic [WIDTH-1:0]        seed_in,
  input  logic [3:0]              amp_shift,
  lfsr_noise_bank_if.master       out_if,
  output logic                    lockup_flag,
  output logic [31:0]             sample_count
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];

  logic [WIDTH-1:0]            ch_state [NUM_CH];
  logic [NUM_CH-1:0]           ch_load;
  logic [NUM_CH-1:0]           ch_zero;
  logic [NUM_CH*OUT_WIDTH-1:0] sample_vec;
  logic [NUM_CH*OUT_WIDTH-1:0] noise_q;
  logic                        vld_q;
  logic                        flag_q;
  logic [31:0]                 cnt_q;
  logic                        adv;
  logic                        xfer;

  assign xfer = vld_q && out_if.out_ready;
  assign adv  = enable && (!vld_q || out_if.out_ready);

  // Top OUT_WIDTH bits of the state; signed mode flips the MSB to centre the range on zero.
  function automatic logic [OUT_WIDTH-1:0] scale(input logic [OUT_WIDTH-1:0] s,
                                                 input logic [3:0]           sh);
    logic [OUT_WIDTH-1:0] v;
    v = s;
    if (SIGNED_OUT) begin
      v[OUT_WIDTH-1] = ~v[OUT_WIDTH-1];
      if (int'(sh) >= OUT_WIDTH) v = {OUT_WIDTH{v[OUT_WIDTH-1]}};
      else                       v = $unsigned($signed(v) >>> sh);
    end else begin
      if (int'(sh) >= OUT_WIDTH) v = '0;
      else                       v = v >> sh;
    end
    return v;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [31:0] INIT32 = rot_seed(SEED, WIDTH, c);

    assign ch_load[c] = seed_load && (seed_ch == CH_W'(c));

    lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAP_MASK),
      .INIT  (INIT32[WIDTH-1:0])
    ) u_core (
      .clk       (clk),
      .reset     (reset),
      .adv       (adv),
      .load      (ch_load[c]),
      .load_val  (seed_in),
      .state     (ch_state[c]),
      .zero_seed (ch_zero[c])
    );

    assign sample_vec[c*OUT_WIDTH +: OUT_WIDTH] = scale(ch_state[c][WIDTH-1 -: OUT_WIDTH], amp_shift);
  end

  // The output register captures the pre-advance state on the same edge the LFSRs step.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= 1'b0;
      noise_q <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (adv) begin
        noise_q <= sample_vec;
        vld_q   <= 1'b1;
      end else if (xfer) begin
        vld_q   <= 1'b0;
      end
      if (xfer)      cnt_q  <= cnt_q + 32'd1;
      if (|ch_zero)  flag_q <= 1'b1;
    end
  end

  assign out_if.out_valid = vld_q;
  assign out_if.noise_out = noise_q;
  assign lockup_flag      = flag_q;
  assign sample_count     = cnt_q;

endmodule

// File: tb/tb_lfsr_noise_bank.sv
// Bench for lfsr_noise_bank: scoreboard over the output stream plus hand-computed vectors.
module tb_lfsr_noise_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        seed_load;
  logic [1:0]  seed_ch;
  logic [15:0] seed_in;
  logic [3:0]  amp_shift;
  logic        lockup_flag;
  logic [31:0] sample_count;

  logic        enable3;
  logic        seed_load3;
  logic [1:0]  seed_ch3;
  logic [15:0] seed_in3;
  logic        lockup_flag3;
  logic [31:0] sample_count3;

  always #5 clk = ~clk;

  lfsr_noise_bank_if #(.NUM_CH(4), .OUT_WIDTH(16)) bus ();
  lfsr_noise_bank_if #(.NUM_CH(3), .OUT_WIDTH(16)) bus3 ();

  lfsr_noise_bank #(
    .WIDTH(16), .OUT_WIDTH(16), .NUM_CH(4),
    .TAPS(32'h0000_B400), .SEED(32'h0000_ACE1), .SIGNED_OUT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed_ch(seed_ch), .seed_in(seed_in), .amp_shift(amp_shift),
    .out_if(bus), .lockup_flag(lockup_flag), .sample_count(sample_count)
  );

  lfsr_noise_bank #(.NUM_CH(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .seed_load(seed_load3),
    .seed_ch(seed_ch3), .seed_in(seed_in3), .amp_shift(amp_shift),
    .out_if(bus3), .lockup_flag(lockup_flag3), .sample_count(sample_count3)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_state [4];
  bit          m_vld;
  logic [31:0] m_cnt;
  bit          m_flag;
  bit          zero_seen;
  logic [63:0] sb [$];

  typedef struct {
    logic [15:0] seed;
    logic [3:0]  amp;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] nxt16(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
    logic [31:0] d;
    d = {x, x} << n;
    return d[31:16];
  endfunction

  function automatic logic [15:0] samp16(input logic [15:0] x, input logic [3:0] amp);
    logic [15:0] s;
    s = x ^ 16'h8000;
    for (int i = 0; i < 16; i++)
      if (i < int'(amp)) s = {s[15], s[15:1]};
    return s;
  endfunction

  function automatic logic [63:0] samp_vec(input logic [3:0] amp);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = samp16(m_state[c], amp);
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_state[c] = rotl16(16'hACE1, (3 * c) % 16);
      if (m_state[c] == 16'h0) m_state[c] = 16'h1;
    end
    m_vld  = 1'b0;
    m_cnt  = '0;
    m_flag = 1'b0;
    sb.delete();
  endtask

  // One clock: drive inputs, update the model for this edge, then compare after the edge.
  task automatic cyc(input bit en, input bit rdy, input bit ld, input logic [1:0] ch,
                     input logic [15:0] sin, input logic [3:0] amp);
    bit adv;
    enable = en; bus.out_ready = rdy; seed_load = ld; seed_ch = ch; seed_in = sin; amp_shift = amp;
    adv = en && (!m_vld || rdy);
    if (m_vld && rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: transfer with empty scoreboard");
      end else begin
        void'(sb.pop_front());
      end
      m_cnt++;
    end
    if (adv) begin
      sb.push_back(samp_vec(amp));
      for (int c = 0; c < 4; c++) m_state[c] = nxt16(m_state[c]);
      m_vld = 1'b1;
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
    if (ld) begin
      m_state[ch] = (sin == 16'h0) ? 16'h1 : sin;
      if (sin == 16'h0) m_flag = 1'b1;
    end
    @(posedge clk); #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
    chk("sample_count", 64'(sample_count), 64'(m_cnt));
    chk("lockup_flag", 64'(lockup_flag), 64'(m_flag));
    if (m_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: out_valid=1 got %h expected none", bus.noise_out);
      end else begin
        chk("noise_out", bus.noise_out, sb[0]);
      end
      if (bus.noise_out[15:0] == 16'h8000) zero_seen = 1'b1;
    end
  endtask

  initial begin
    tbl[0] = '{16'hACE1, 4'd0,  16'h2CE1};
    tbl[1] = '{16'hACE1, 4'd4,  16'h02CE};
    tbl[2] = '{16'hACE1, 4'd15, 16'h0000};
    tbl[3] = '{16'h2CE1, 4'd15, 16'hFFFF};
    tbl[4] = '{16'h2CE1, 4'd4,  16'hFACE};
    tbl[5] = '{16'hFFFF, 4'd1,  16'h3FFF};
    tbl[6] = '{16'h0001, 4'd3,  16'hF000};

    reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_ch = '0; seed_in = '0; amp_shift = '0;
    bus.out_ready = 1'b0;
    enable3 = 1'b0; seed_load3 = 1'b0; seed_ch3 = '0; seed_in3 = '0; bus3.out_ready = 1'b0;
    zero_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_noise", bus.noise_out, 64'd0);
    chk("rst_flag", 64'(lockup_flag), 64'd0);
    chk("rst_count", 64'(sample_count), 64'd0);

    // Out-of-range channel select on a 3-channel bank must not touch any channel or the flag.
    seed_load3 = 1'b1; seed_ch3 = 2'd3; seed_in3 = 16'h0000;
    @(posedge clk); #1;
    seed_load3 = 1'b0; enable3 = 1'b1;
    @(posedge clk); #1;
    enable3 = 1'b0;
    chk("oor_flag", 64'(lockup_flag3), 64'd0);
    chk("oor_noise", 64'(bus3.noise_out), 64'h0000_B86B_E70D_2CE1);
    chk("oor_valid", 64'(bus3.out_valid), 64'd1);
    chk("oor_count", 64'(sample_count3), 64'd0);

    // Full period of channel 0.
    cyc(1, 1, 0, 0, 16'h0, 4'd0);
    chk("first_vec", bus.noise_out, 64'h4359_B86B_E70D_2CE1);
    cyc(1, 1, 0, 0, 16'h0, 4'd0);
    chk("ch0_second", 64'(bus.noise_out[15:0]), 64'h0000_D9C3);
    for (int i = 2; i < 65535; i++) cyc(1, 1, 0, 0, 16'h0, 4'd0);
    cyc(0, 1, 0, 0, 16'h0, 4'd0);
    chk("period_count", 64'(sample_count), 64'd65535);
    chk("period_nozero", 64'(zero_seen), 64'd0);
    cyc(1, 1, 0, 0, 16'h0, 4'd0);
    chk("period_wrap", 64'(bus.noise_out[15:0]), 64'h0000_2CE1);

    // Backpressure: five stalled cycles, then the next state in sequence.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 16'h0, 4'd0);
      chk("stall_ch0", 64'(bus.noise_out[15:0]), 64'h0000_2CE1);
      chk("stall_count", 64'(sample_count), 64'd65535);
    end
    cyc(1, 1, 0, 0, 16'h0, 4'd0);
    chk("resume_ch0", 64'(bus.noise_out[15:0]), 64'h0000_D9C3);
    cyc(1, 1, 0, 0, 16'h0, 4'd0);

    // Zero seed into ch2, then a load on ch1 concurrent with an advance.
    cyc(0, 1, 1, 2'd2, 16'h0000, 4'd0);
    chk("lock_flag_set", 64'(lockup_flag), 64'd1);
    cyc(1, 1, 1, 2'd1, 16'h1234, 4'd0);
    chk("zero_sub_ch2", 64'(bus.noise_out[47:32]), 64'h0000_8001);
    cyc(1, 1, 0, 0, 16'h0, 4'd0);
    chk("load_ch1", 64'(bus.noise_out[31:16]), 64'h0000_9234);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 16'h0, 4'd0);
    chk("lock_sticky", 64'(lockup_flag), 64'd1);

    // Amplitude scaling vectors on ch0.
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 1, 2'd0, tbl[i].seed, 4'd0);
      cyc(1, 1, 0, 2'd0, 16'h0, tbl[i].amp);
      chk($sformatf("amp_tbl%0d", i), 64'(bus.noise_out[15:0]), 64'(tbl[i].exp));
    end

    // Reset in the middle of a stalled handshake.
    cyc(1, 1, 0, 0, 16'h0, 4'd0);
    cyc(1, 0, 0, 0, 16'h0, 4'd0);
    reset = 1'b1; enable = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_flag", 64'(lockup_flag), 64'd0);
    chk("rst_mid_count", 64'(sample_count), 64'd0);
    reset = 1'b0;
    model_reset();
    cyc(1, 1, 0, 0, 16'h0, 4'd0);
    chk("rst_mid_seeds", bus.noise_out, 64'h4359_B86B_E70D_2CE1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
